// File: rtl/ro_puf_resp_ctrl.sv
// Purpose: sequences a dual-bank RO PUF. For each bit it picks a challenge pair, clears the
//          counters, runs one enable window, lets the counters settle, compares them and packs the bit.
// Latency: 2+WINDOW+SETTLE_CYC cycles per bit. resp_valid comes RESP_W*(2+WINDOW+SETTLE_CYC)+1 cycles after start.
// Backpressure: resp_valid and the result stay held in DONE until resp_ready. A start while busy is dropped.
module ro_puf_resp_ctrl #(
    parameter int RESP_W     = 32,
    parameter int CNT_W      = 16,
    parameter int WINDOW     = 1024,
    parameter int SETTLE_CYC = 4,
    localparam int TIE_W     = $clog2(RESP_W + 1),
    localparam int KW        = (RESP_W > 1) ? $clog2(RESP_W) : 1,
    localparam int TMAX      = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC,
    localparam int TW        = $clog2(TMAX + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [7:0]        i_chall_base,
    input  logic [CNT_W-1:0]  i_count0,
    input  logic [CNT_W-1:0]  i_count1,
    output logic [7:0]        o_chall0,
    output logic [7:0]        o_chall1,
    output logic              o_cnten,
    output logic              o_cnt_clr,
    output logic              o_busy,
    output logic [RESP_W-1:0] o_resp,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [TIE_W-1:0]  o_tie_cnt,
    output logic              o_sat
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_MEASURE, S_SETTLE, S_COMPARE, S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nxt;
    logic [TW-1:0]      r_tmr;
    logic [KW-1:0]      r_k;
    logic [KW-1:0]      w_k_nxt;
    logic [7:0]         r_base;
    logic [7:0]         w_base_nxt;
    logic [7:0]         w_off;
    logic [7:0]         r_chall0;
    logic [7:0]         r_chall1;
    logic               r_cnten;
    logic               r_cnt_clr;
    logic               r_busy;
    logic               r_resp_valid;
    logic [RESP_W-1:0]  r_resp;
    logic [TIE_W-1:0]   r_tie;
    logic               r_sat;
    logic               w_last;
    logic               w_accept;

    assign w_last   = (r_k == KW'(RESP_W - 1));
    assign w_accept = (r_state == S_IDLE) && i_start;

    // Next-state decode, plus the bit index and base that the next CLEAR will use.
    always_comb begin
        w_nxt      = r_state;
        w_k_nxt    = r_k;
        w_base_nxt = r_base;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_nxt      = S_CLEAR;
                    w_k_nxt    = '0;
                    w_base_nxt = i_chall_base;
                end
            end
            S_CLEAR:   w_nxt = S_MEASURE;
            S_MEASURE: if (r_tmr == TW'(WINDOW - 1))     w_nxt = S_SETTLE;
            S_SETTLE:  if (r_tmr == TW'(SETTLE_CYC - 1)) w_nxt = S_COMPARE;
            S_COMPARE: begin
                if (w_last) begin
                    w_nxt = S_DONE;
                end else begin
                    w_nxt   = S_CLEAR;
                    w_k_nxt = r_k + KW'(1);
                end
            end
            S_DONE:    if (i_resp_ready) w_nxt = S_IDLE;
            default:   w_nxt = S_IDLE;
        endcase
    end

    // Pair k uses base+2k and base+2k+1. The 8-bit add wraps at 256.
    assign w_off = 8'(w_k_nxt) << 1;

    // State register, phase timer, and the Moore outputs, which are registered from the next state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_tmr        <= '0;
            r_k          <= '0;
            r_base       <= '0;
            r_chall0     <= '0;
            r_chall1     <= '0;
            r_cnten      <= 1'b0;
            r_cnt_clr    <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_state      <= w_nxt;
            r_k          <= w_k_nxt;
            r_base       <= w_base_nxt;
            r_tmr        <= (w_nxt == r_state) ? r_tmr + TW'(1) : '0;
            r_cnten      <= (w_nxt == S_MEASURE);
            r_cnt_clr    <= (w_nxt == S_CLEAR);
            r_busy       <= (w_nxt != S_IDLE);
            r_resp_valid <= (w_nxt == S_DONE);
            if (w_nxt == S_CLEAR) begin
                r_chall0 <= w_base_nxt + w_off;
                r_chall1 <= w_base_nxt + w_off + 8'd1;
            end
        end
    end

    // Result accumulation: cleared on an accepted start, updated once per COMPARE.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_resp <= '0;
            r_tie  <= '0;
            r_sat  <= 1'b0;
        end else if (w_accept) begin
            r_resp <= '0;
            r_tie  <= '0;
            r_sat  <= 1'b0;
        end else if (r_state == S_COMPARE) begin
            r_resp[r_k] <= (i_count0 > i_count1);
            if (i_count0 == i_count1) begin
                r_tie <= r_tie + TIE_W'(1);
            end
            if ((&i_count0) || (&i_count1)) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign o_chall0     = r_chall0;
    assign o_chall1     = r_chall1;
    assign o_cnten      = r_cnten;
    assign o_cnt_clr    = r_cnt_clr;
    assign o_busy       = r_busy;
    assign o_resp       = r_resp;
    assign o_resp_valid = r_resp_valid;
    assign o_tie_cnt    = r_tie;
    assign o_sat        = r_sat;

endmodule
